sr_button_conditioner: RTL and testbench



---
 rtl/sr_cond_pkg.sv | 26 ++
 rtl/sr_debounce.sv | 51 +++++
 rtl/sr_button_conditioner.sv | 73 +++++++
 tb/tb_sr_button_conditioner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sr_cond_pkg.sv
// Shared types and constants for the SR button conditioner.
// Holds the arbitration command encoding and the synchroniser depth.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SET,
    CMD_RESET,
    CMD_CONFLICT
  } sr_cmd_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Fixed arbitration: coincident command events are always flagged as a conflict.
  function automatic sr_cmd_t arbitrate(input logic set_ev, input logic reset_ev);
    sr_cmd_t cmd;
    unique case ({set_ev, reset_ev})
      2'b10:   cmd = CMD_SET;
      2'b01:   cmd = CMD_RESET;
      2'b11:   cmd = CMD_CONFLICT;
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchroniser, consecutive-cycle stability counter,
// accepted level and single-cycle rising-edge event.
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync2;
  logic                   stable;
  logic                   stable_q;
  logic [CNT_W-1:0]       cnt;

  assign sync2 = sync[SYNC_STAGES-1];

  // NOTE: every register here updates with <= so all of them see the
  // pre-edge values of each other, which is what the counter/stable
  // comparison below relies on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], btn};
      stable_q <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Only presses generate events; releases are absorbed silently.
  assign rise = stable & ~stable_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// Debounced set/reset command generator feeding an SR flip-flop stage.
// Build option: define SR_COND_INVALID_PASS_EN to pass coincident commands as S=R=1.
module sr_button_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic conflict
);

  logic    set_rise;
  logic    reset_rise;
  sr_cmd_t cmd;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_set),
    .rise  (set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_ch (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_reset),
    .rise  (reset_rise)
  );

  assign cmd = arbitrate(set_rise, reset_rise);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      S        <= 1'b0;
      R        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      unique case (cmd)
        CMD_SET: begin
          S        <= 1'b1;
          R        <= 1'b0;
          conflict <= 1'b0;
        end
        CMD_RESET: begin
          S        <= 1'b0;
          R        <= 1'b1;
          conflict <= 1'b0;
        end
        CMD_CONFLICT: begin
`ifdef SR_COND_INVALID_PASS_EN
          S        <= 1'b1;
          R        <= 1'b1;
`else
          S        <= 1'b0;
          R        <= 1'b0;
`endif
          conflict <= 1'b1;
        end
        default: begin
          S        <= 1'b0;
          R        <= 1'b0;
          conflict <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Scoreboard bench for sr_button_conditioner with DEBOUNCE_CYCLES=4.
// Stimulus queues expected pulses by cycle; the monitor checks outputs every cycle.
module tb_sr_button_conditioner;

  localparam int unsigned D   = 4;
  localparam int unsigned LAT = D + 3;  // drive at negedge -> pulse seen at that many negedges later

`ifdef SR_COND_INVALID_PASS_EN
  localparam logic CONF_SR = 1'b1;
`else
  localparam logic CONF_SR = 1'b0;
`endif

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic btn_set   = 1'b1;
  logic btn_reset = 1'b1;
  logic S, R, conflict;

  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    int unsigned at;
    logic [2:0]  src;
    string       name;
  } exp_t;

  exp_t sb[$];

  sr_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_set   (btn_set),
    .btn_reset (btn_reset),
    .S         (S),
    .R         (R),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got S,R,conflict=%b want %b", name, cyc, act, req);
    end
  endtask

  task automatic expect_at(input int unsigned at, input logic s, input logic r,
                           input logic c, input string name);
    exp_t e;
    e.at   = at;
    e.src  = {s, r, c};
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle the outputs must match either the due scoreboard entry or all-zero.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] want;
    string      nm;
    want = 3'b000;
    nm   = "idle";
    if (sb.size() > 0 && sb[0].at <= cyc) begin
      e    = sb.pop_front();
      want = e.src;
      nm   = (e.at == cyc) ? e.name : {e.name, "_late"};
    end
    check(nm, {S, R, conflict}, want);
  end

  initial begin
    // Power-up: both buttons held through a 20 ns reset, then released reset.
    idle(2);
    reset = 1'b0;
    expect_at(cyc + LAT, CONF_SR, CONF_SR, 1'b1, "powerup_conflict");
    idle(10);
    btn_set   = 1'b0;
    btn_reset = 1'b0;
    idle(15);

    // Set held for 10 cycles: exactly one S pulse.
    btn_set = 1'b1;
    expect_at(cyc + LAT, 1'b1, 1'b0, 1'b0, "set_hold");
    idle(10);
    btn_set = 1'b0;
    idle(15);

    // Reset bouncing with 2-cycle runs, then held: one R pulse after the final rise.
    for (int i = 0; i < 12; i++) begin
      btn_reset = ((i % 4) < 2);
      idle(1);
    end
    btn_reset = 1'b1;
    expect_at(cyc + LAT, 1'b0, 1'b1, 1'b0, "reset_bounce");
    idle(10);
    btn_reset = 1'b0;
    idle(15);

    // Staggered presses: separate S then R, no conflict.
    btn_set = 1'b1;
    expect_at(cyc + LAT, 1'b1, 1'b0, 1'b0, "stagger_set");
    idle(3);
    btn_reset = 1'b1;
    expect_at(cyc + LAT, 1'b0, 1'b1, 1'b0, "stagger_reset");
    idle(12);
    btn_set   = 1'b0;
    btn_reset = 1'b0;
    idle(15);

    // Coincident presses.
    btn_set   = 1'b1;
    btn_reset = 1'b1;
    expect_at(cyc + LAT, CONF_SR, CONF_SR, 1'b1, "coincident");
    idle(10);
    btn_set   = 1'b0;
    btn_reset = 1'b0;
    idle(15);

    // Reset in the middle of a debounce count: no pulse afterwards.
    btn_set = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(2);
    btn_set = 1'b0;
    reset   = 1'b0;
    idle(20);

    // Reset asserted while a pulse is on the outputs clears it immediately.
    btn_set = 1'b1;
    expect_at(cyc + LAT, 1'b1, 1'b0, 1'b0, "inflight_pulse");
    idle(LAT);
    #1 reset = 1'b1;
    #1 check("inflight_clear", {S, R, conflict}, 3'b000);
    btn_set = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(15);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s_missing expected at cycle=%0d want S,R,conflict=%b never seen",
               e.name, e.at, e.src);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
